mips_load_store_unit: RTL and testbench

//   Sits between the MEM pipeline stage and mips_data_mem; converts byte/half/word load-store requests

---
 rtl/mips_load_store_unit.sv | 159 +++++++++++++++
 tb/tb_mips_load_store_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_load_store_unit.sv
// Byte/half/word load-store front end for a word-wide data memory.
// Sub-word stores are done as read-modify-write; misaligned or unknown requests never touch memory.
module mips_load_store_unit #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_misaligned,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  signal_mem_read,
    output logic                  signal_mem_write,
    input  logic [31:0]           mem_read_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [3:0] OP_SW = 4'b1011;

    logic [1:0]  state;
    logic [3:0]  op_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        op_known;
    logic        req_misaligned;
    logic [1:0]  req_lane;

    logic [1:0]  lane_sel;
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] rd_shift_b;
    logic [31:0] rd_shift_h;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;
    logic [31:0] load_ext;
    logic [31:0] store_merged;

    assign req_ready        = (state == IDLE);
    assign resp_valid       = (state == RESP);
    assign signal_mem_read  = (state == RD);
    assign signal_mem_write = (state == WR);

    // Request decode: op legality, alignment and the lane actually addressed.
    always_comb begin
        op_known = 1'b0;
        unique case (req_op)
            4'b0000, 4'b0001, 4'b0011, 4'b0100,
            4'b0101, 4'b1000, 4'b1001, 4'b1011: op_known = 1'b1;
            default:                            op_known = 1'b0;
        endcase

        req_misaligned = !op_known ||
            (ALIGN_CHECK && ((req_op[1:0] == 2'b01) && req_addr[0])) ||
            (ALIGN_CHECK && ((req_op[1:0] == 2'b11) && (req_addr[1:0] != 2'b00)));

        req_lane = 2'b00;
        unique case (req_op[1:0])
            2'b00:   req_lane = req_addr[1:0];
            2'b01:   req_lane = {req_addr[1], 1'b0};
            default: req_lane = 2'b00;
        endcase
    end

    // Lane extraction and merge, shared by loads and sub-word stores.
    always_comb begin
        lane_sel   = BIG_ENDIAN ? ~lane_q : lane_q;
        byte_shift = {lane_sel, 3'b000};
        half_shift = {lane_sel[1], 4'b0000};

        rd_shift_b = mem_read_data >> byte_shift;
        rd_shift_h = mem_read_data >> half_shift;
        rd_byte    = rd_shift_b[7:0];
        rd_half    = rd_shift_h[15:0];

        byte_mask = 32'h0000_00ff << byte_shift;
        half_mask = 32'h0000_ffff << half_shift;

        load_ext = mem_read_data;
        unique case (op_q[1:0])
            2'b00:   load_ext = op_q[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = op_q[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_ext = mem_read_data;
        endcase

        if (op_q[1:0] == 2'b00) begin
            store_merged = (mem_read_data & ~byte_mask) | ({24'b0, wdata_q[7:0]} << byte_shift);
        end else begin
            store_merged = (mem_read_data & ~half_mask) | ({16'b0, wdata_q} << half_shift);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            op_q            <= 4'b0;
            lane_q          <= 2'b0;
            wdata_q         <= 16'b0;
            resp_rdata      <= 32'b0;
            resp_misaligned <= 1'b0;
            mem_address     <= '0;
            mem_write_data  <= 32'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_misaligned) begin
                            resp_rdata      <= 32'b0;
                            resp_misaligned <= 1'b1;
                            state           <= RESP;
                        end else begin
                            op_q        <= req_op;
                            lane_q      <= req_lane;
                            wdata_q     <= req_wdata[15:0];
                            mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            if (req_op == OP_SW) begin
                                mem_write_data <= req_wdata;
                                state          <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (op_q[3]) begin
                        mem_write_data <= store_merged;
                        state          <= WR;
                    end else begin
                        resp_rdata      <= load_ext;
                        resp_misaligned <= 1'b0;
                        state           <= RESP;
                    end
                end
                WR: begin
                    resp_rdata      <= 32'b0;
                    resp_misaligned <= 1'b0;
                    state           <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Randomised bench for mips_load_store_unit against a byte-array memory model.
module tb_mips_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        signal_mem_read;
    logic        signal_mem_write;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    mips_load_store_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_misaligned  (resp_misaligned),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .signal_mem_read  (signal_mem_read),
        .signal_mem_write (signal_mem_write),
        .mem_read_data    (mem_read_data)
    );

    // Word memory seen by the DUT; preload goes through the same process as DUT writes.
    logic [31:0] dut_mem [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;

    assign mem_read_data = dut_mem[mem_address[5:2]];

    always @(posedge clk) begin
        if (signal_mem_write) dut_mem[mem_address[5:2]] <= mem_write_data;
        else if (pre_we)      dut_mem[pre_idx] <= pre_val;
    end

    // Reference: plain byte-addressed big-endian memory.
    logic [7:0] refb [64];

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int wi);
        return {refb[4*wi], refb[4*wi+1], refb[4*wi+2], refb[4*wi+3]};
    endfunction

    task automatic preload(input int wi, input logic [31:0] v);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = wi[3:0];
        pre_val = v;
        refb[4*wi]   = v[31:24];
        refb[4*wi+1] = v[23:16];
        refb[4*wi+2] = v[15:8];
        refb[4*wi+3] = v[7:0];
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] w,
                         output logic [31:0] rdata, output logic mis, output int lat,
                         output int nrd, output int nwr);
        int a = int'(addr[5:0]);
        logic [15:0] h;
        rdata = 32'b0; mis = 1'b0; lat = 2; nrd = 0; nwr = 0;
        case (op)
            4'b0000: begin rdata = {{24{refb[a][7]}}, refb[a]}; nrd = 1; end
            4'b0100: begin rdata = {24'b0, refb[a]}; nrd = 1; end
            4'b0001, 4'b0101: begin
                if (a % 2 != 0) mis = 1'b1;
                else begin
                    h = {refb[a], refb[a+1]};
                    rdata = (op == 4'b0001) ? {{16{h[15]}}, h} : {16'b0, h};
                    nrd = 1;
                end
            end
            4'b0011: begin
                if (a % 4 != 0) mis = 1'b1;
                else begin rdata = {refb[a], refb[a+1], refb[a+2], refb[a+3]}; nrd = 1; end
            end
            4'b1000: begin refb[a] = w[7:0]; lat = 3; nrd = 1; nwr = 1; end
            4'b1001: begin
                if (a % 2 != 0) mis = 1'b1;
                else begin
                    refb[a] = w[15:8]; refb[a+1] = w[7:0];
                    lat = 3; nrd = 1; nwr = 1;
                end
            end
            4'b1011: begin
                if (a % 4 != 0) mis = 1'b1;
                else begin
                    refb[a] = w[31:24]; refb[a+1] = w[23:16];
                    refb[a+2] = w[15:8]; refb[a+3] = w[7:0];
                    nwr = 1;
                end
            end
            default: mis = 1'b1;
        endcase
        if (mis) lat = 1;
    endtask

    task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] w,
                           output logic [31:0] rdata, output logic mis, output int lat,
                           output int nrd, output int nwr, output logic both);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_wait", 32'(guard < 10), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = w;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0; nrd = 0; nwr = 0; both = 1'b0; rdata = 32'hx; mis = 1'bx;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (signal_mem_read)  nrd++;
            if (signal_mem_write) nwr++;
            if (signal_mem_read && signal_mem_write) both = 1'b1;
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; mis = resp_misaligned;
            end
        end
    endtask

    task automatic check_txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] w);
        logic [31:0] er, gr;
        logic em, gm, gb;
        int el, gl, erd, grd, ewr, gwr;
        model(op, addr, w, er, em, el, erd, ewr);
        run_req(op, addr, w, gr, gm, gl, grd, gwr, gb);
        check_eq({tag, "_rdata"}, gr, er);
        check_eq({tag, "_mis"}, 32'(gm), 32'(em));
        check_eq({tag, "_lat"}, gl, el);
        check_eq({tag, "_reads"}, grd, erd);
        check_eq({tag, "_writes"}, gwr, ewr);
        check_eq({tag, "_both"}, 32'(gb), 32'd0);
    endtask

    logic [3:0]  op_pool [12];
    logic [31:0] r;
    logic        m, b;
    int          l, nr, nw;
    int          resp_cnt, t1, t2;
    logic [31:0] second_rdata;

    initial begin
        op_pool = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1000,
                    4'b1001, 4'b1011, 4'b0010, 4'b0110, 4'b1100, 4'b1111};

        // Reset with a request pending: nothing may happen.
        rst_n = 1'b0; req_valid = 1'b1; req_op = 4'b0011; req_addr = 32'h4; req_wdata = 32'h0;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        @(negedge clk);
        check_eq("rst_read",   32'(signal_mem_read),  32'd0);
        check_eq("rst_write",  32'(signal_mem_write), 32'd0);
        check_eq("rst_resp",   32'(resp_valid),       32'd0);
        check_eq("rst_ready",  32'(req_ready),        32'd1);
        check_eq("rst_rdata",  resp_rdata,            32'd0);
        check_eq("rst_addr",   mem_address,           32'd0);
        check_eq("rst_wdata",  mem_write_data,        32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Loads from a known word.
        preload(1, 32'hBC1F0F83);
        run_req(4'b0000, 32'h4, 32'h0, r, m, l, nr, nw, b);
        check_eq("lb", r, 32'hFFFFFFBC);
        check_eq("lb_lat", l, 2);
        run_req(4'b0100, 32'h4, 32'h0, r, m, l, nr, nw, b);
        check_eq("lbu", r, 32'h000000BC);
        run_req(4'b0001, 32'h6, 32'h0, r, m, l, nr, nw, b);
        check_eq("lh", r, 32'h00000F83);
        run_req(4'b0011, 32'h4, 32'h0, r, m, l, nr, nw, b);
        check_eq("lw", r, 32'hBC1F0F83);
        check_eq("lw_lat", l, 2);

        // Byte store read-modify-write.
        preload(1, 32'hF33333B3);
        check_txn("sb", 4'b1000, 32'h6, 32'h000000AA);
        check_eq("sb_mem", dut_mem[1], 32'hF333AAB3);

        // Misaligned requests.
        check_txn("lw_mis", 4'b0011, 32'h6, 32'h0);
        check_txn("sh_mis", 4'b1001, 32'h5, 32'h1234);

        // Reset while the SH write strobe is up.
        preload(1, 32'h55667788);
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b1001; req_addr = 32'h4; req_wdata = 32'h1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rmw_wr_up", 32'(signal_mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rmw_wr_drop", 32'(signal_mem_write), 32'd0);
        check_eq("rmw_no_resp", 32'(resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rmw_mem_kept", dut_mem[1], 32'h55667788);
        @(negedge clk);
        rst_n = 1'b1;

        // SW then LW with req_valid held throughout.
        model(4'b1011, 32'h8, 32'hDEADBEEF, r, m, l, nr, nw);
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b1011; req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_op = 4'b0011; req_wdata = 32'h0;
        resp_cnt = 0; t1 = 0; t2 = 0; second_rdata = 32'h0;
        for (int c = 1; c <= 10 && resp_cnt < 2; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                resp_cnt++;
                if (resp_cnt == 1) begin
                    t1 = c;
                    check_eq("b2b_ready_in_resp", 32'(req_ready), 32'd0);
                end else begin
                    t2 = c;
                    second_rdata = resp_rdata;
                end
            end else if (resp_cnt == 1 && req_ready) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check_eq("b2b_first_lat", t1, 2);
        check_eq("b2b_gap", t2 - t1, 3);
        check_eq("b2b_rdata", second_rdata, 32'hDEADBEEF);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            check_txn($sformatf("rnd%0d", i), op_pool[$urandom_range(0, 11)],
                      32'($urandom_range(0, 63)), $urandom);
        end
        for (int i = 0; i < 16; i++) check_eq($sformatf("mem%0d", i), dut_mem[i], ref_word(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
